// File: rtl/leitor_teclado_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | leitor_teclado_pkg                                                     |
// | Key codes, FSM state encoding and lookup helpers shared by the keypad  |
// | reader and the calculator datapath that consumes its key codes.        |
// | Ports: none (package).                                                 |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package leitor_teclado_pkg;

  // Key codes as seen by the calculator
  localparam logic [3:0] T_0  = 4'd0;
  localparam logic [3:0] T_1  = 4'd1;
  localparam logic [3:0] T_2  = 4'd2;
  localparam logic [3:0] T_3  = 4'd3;
  localparam logic [3:0] T_4  = 4'd4;
  localparam logic [3:0] T_5  = 4'd5;
  localparam logic [3:0] T_6  = 4'd6;
  localparam logic [3:0] T_7  = 4'd7;
  localparam logic [3:0] T_8  = 4'd8;
  localparam logic [3:0] T_9  = 4'd9;
  localparam logic [3:0] ASTE = 4'd10;
  localparam logic [3:0] HASH = 4'd11;
  localparam logic [3:0] T_A  = 4'd12;
  localparam logic [3:0] T_B  = 4'd13;
  localparam logic [3:0] T_C  = 4'd14;
  localparam logic [3:0] T_D  = 4'd15;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } estado_t;

  // Physical layout:  r0 = 1 2 3 A / r1 = 4 5 6 B / r2 = 7 8 9 C / r3 = * 0 # D
  function automatic logic [3:0] codigo_tecla(input logic [1:0] linha,
                                              input logic [1:0] coluna);
    logic [3:0] codigo;
    case ({linha, coluna})
      4'b00_00: codigo = T_1;
      4'b00_01: codigo = T_2;
      4'b00_10: codigo = T_3;
      4'b00_11: codigo = T_A;
      4'b01_00: codigo = T_4;
      4'b01_01: codigo = T_5;
      4'b01_10: codigo = T_6;
      4'b01_11: codigo = T_B;
      4'b10_00: codigo = T_7;
      4'b10_01: codigo = T_8;
      4'b10_10: codigo = T_9;
      4'b10_11: codigo = T_C;
      4'b11_00: codigo = ASTE;
      4'b11_01: codigo = T_0;
      4'b11_10: codigo = HASH;
      default:  codigo = T_D;
    endcase
    return codigo;
  endfunction

  // Lowest-indexed active-low row; only meaningful when some bit is low
  function automatic logic [1:0] linha_ativa(input logic [3:0] linhas);
    logic [1:0] idx;
    casez (linhas)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/leitor_teclado_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | leitor_teclado_if                                                      |
// | Keypad-side and calculator-side signals of the keypad reader.          |
// | Signals: linhas[3:0]  rows from keypad, active-low, asynchronous       |
// |          colunas[3:0] column drive, active-low, one-hot-low            |
// |          tecla_atual[3:0] last accepted key code                       |
// |          ativo        one-cycle strobe for a newly accepted key        |
// | Modports: master = keypad reader, slave = keypad + calculator side.    |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
interface leitor_teclado_if;
  logic [3:0] linhas;
  logic [3:0] colunas;
  logic [3:0] tecla_atual;
  logic       ativo;

  modport master (
    input  linhas,
    output colunas,
    output tecla_atual,
    output ativo
  );

  modport slave (
    output linhas,
    input  colunas,
    input  tecla_atual,
    input  ativo
  );
endinterface
`default_nettype wire

// File: rtl/leitor_teclado_sincronizador.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sincronizador                                                          |
// | Two-flop synchronizer for the 4 asynchronous keypad row lines.         |
// | Resets to 4'b1111 (no row active).                                     |
// | Ports: clk, rst (async, active-high), d[3:0] async in, q[3:0] synced.  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module sincronizador (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;
  logic [3:0] estavel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta    <= 4'b1111;
      estavel <= 4'b1111;
    end else begin
      meta    <= d;
      estavel <= meta;
    end
  end

  assign q = estavel;
endmodule
`default_nettype wire

// File: rtl/leitor_teclado.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | leitor_teclado                                                         |
// | 4x4 matrix keypad scanner with debounce; emits one key code and a      |
// | single-cycle ativo strobe per physical key press.                      |
// | Ports: clk            system clock                                     |
// |        rst            asynchronous active-high reset                   |
// |        bus (master)   linhas in, colunas / tecla_atual / ativo out     |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module leitor_teclado
  import leitor_teclado_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,   // >= 3 to cover the synchronizer delay
  parameter int DEBOUNCE_CYCLES = 16   // >= 1
) (
  input  logic             clk,
  input  logic             rst,
  leitor_teclado_if.master bus
);

  localparam int MAX_CNT = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  estado_t          state, state_nxt;
  logic [1:0]       col, col_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       padrao, padrao_nxt;   // row pattern that triggered the press
  logic [1:0]       linha, linha_nxt;     // winning (lowest) row of that pattern
  logic [3:0]       colunas_q;
  logic [3:0]       tecla_q;
  logic             ativo_q;
  logic             emitir;
  logic [3:0]       linhas_s;

  sincronizador u_sinc (
    .clk (clk),
    .rst (rst),
    .d   (bus.linhas),
    .q   (linhas_s)
  );

  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    cnt_nxt    = cnt;
    padrao_nxt = padrao;
    linha_nxt  = linha;
    emitir     = 1'b0;

    unique case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nxt = '0;
          if (linhas_s != 4'b1111) begin
            // Hold this column and remember the full pattern so that any
            // added or removed key during debounce is seen as a change.
            padrao_nxt = linhas_s;
            linha_nxt  = linha_ativa(linhas_s);
            state_nxt  = DEBOUNCE;
          end else begin
            col_nxt = col + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      DEBOUNCE: begin
        if (linhas_s != padrao) begin
          state_nxt = SCAN;
          col_nxt   = col + 2'd1;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = EMIT;
          cnt_nxt   = '0;
          emitir    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      EMIT: begin
        state_nxt = WAIT_RELEASE;
        cnt_nxt   = '0;
      end

      WAIT_RELEASE: begin
        // Any low row (same key or another one in this column) restarts
        // the release count, so a short bounce cannot re-trigger.
        if (linhas_s == 4'b1111) begin
          if (cnt == DEB_LAST) begin
            state_nxt = SCAN;
            col_nxt   = col + 2'd1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else begin
          cnt_nxt = '0;
        end
      end

      default: begin
        state_nxt = SCAN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col       <= 2'd0;
      colunas_q <= 4'b1110;
      cnt       <= '0;
      padrao    <= 4'b1111;
      linha     <= 2'd0;
      tecla_q   <= 4'd0;
      ativo_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      colunas_q <= ~(4'b0001 << col_nxt);
      cnt       <= cnt_nxt;
      padrao    <= padrao_nxt;
      linha     <= linha_nxt;
      ativo_q   <= emitir;   // high exactly for the single EMIT cycle
      if (emitir) begin
        tecla_q <= codigo_tecla(linha, col);
      end
    end
  end

  assign bus.colunas     = colunas_q;
  assign bus.tecla_atual = tecla_q;
  assign bus.ativo       = ativo_q;

endmodule
`default_nettype wire

// File: tb/tb_leitor_teclado.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_leitor_teclado                                                      |
// | Directed self-checking bench for leitor_teclado with a 4x4 keypad      |
// | model (row r pulled low while its column is low and the key is held).  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_leitor_teclado;

  logic clk;
  logic rst;
  logic [15:0] keys;   // bit r*4+c = key at row r, column c held

  int total;
  int bad;
  int npulse;
  logic [3:0] pcode;
  logic prev_ativo;
  logic dbl;

  localparam int K_1    = 0;
  localparam int K_A    = 3;
  localparam int K_4    = 4;
  localparam int K_5    = 5;
  localparam int K_9    = 10;
  localparam int K_C    = 11;
  localparam int K_STAR = 12;
  localparam int K_HASH = 14;
  localparam int K_D    = 15;

  leitor_teclado_if bus ();

  leitor_teclado #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.linhas = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !bus.colunas[c]) bus.linhas[r] = 1'b0;
      end
    end
  end

  // Pulse monitor: counts ativo cycles and flags back-to-back pulses
  always @(negedge clk) begin
    if (bus.ativo === 1'b1) begin
      npulse = npulse + 1;
      pcode  = bus.tecla_atual;
      if (prev_ativo) dbl = 1'b1;
    end
    prev_ativo = (bus.ativo === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.colunas === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic key_cycle(input string tag, input int k, input logic [3:0] code);
    int base;
    base = npulse;
    keys = '0;
    keys[k] = 1'b1;
    ticks(40);
    chk({tag, "_pulses"}, npulse - base, 1);
    chk({tag, "_code"}, bus.tecla_atual, code);
    keys = '0;
    ticks(30);
  endtask

  initial begin
    int base;
    int n;
    bit ok;
    bit seen;
    logic [3:0] exp_col;
    logic [3:0] mask;

    total = 0; bad = 0; npulse = 0; pcode = 4'd0;
    prev_ativo = 1'b0; dbl = 1'b0;
    keys = '0;
    rst = 1'b1;

    // ---- reset values
    ticks(3);
    chk("rst_colunas", bus.colunas, 4'b1110);
    chk("rst_ativo", bus.ativo, 1'b0);
    chk("rst_tecla", bus.tecla_atual, 4'd0);

    // ---- idle scanning: each column held for 4 cycles
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1 || k == 3 || (k % 4) == 0) begin
        exp_col = ~(4'b0001 << ((k / 4) % 4));
        chk("scan_colunas", bus.colunas, exp_col);
      end
    end
    ticks(84);
    chk("idle_pulses", npulse, 0);
    chk("idle_tecla", bus.tecla_atual, 4'd0);

    // ---- hold '5' 60 cycles: latency window, single pulse, code held
    base = npulse;
    keys[K_5] = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.ativo === 1'b1) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    chk("k5_latency_in_range", (seen && n >= 7 && n <= 23), 1);
    chk("k5_code_at_pulse", bus.tecla_atual, 4'd5);
    ticks(60 - n);
    chk("k5_pulses_held", npulse - base, 1);
    keys = '0;
    ticks(40);
    chk("k5_pulses_after_release", npulse - base, 1);
    chk("k5_tecla_held", bus.tecla_atual, 4'd5);
    mask = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mask = mask | ~bus.colunas;
    end
    chk("k5_scan_resumed", mask, 4'b1111);

    // ---- bounce: '5' seen for only 2 debounce cycles
    base = npulse;
    wait_col(4'b1110, ok);
    chk("bounce_wait_c0", ok, 1);
    wait_col(4'b1101, ok);
    chk("bounce_wait_c1", ok, 1);
    keys[K_5] = 1'b1;
    ticks(4);
    keys = '0;
    ticks(2);
    chk("bounce_col_held", bus.colunas, 4'b1101);
    ticks(1);
    chk("bounce_next_col", bus.colunas, 4'b1011);
    ticks(20);
    chk("bounce_pulses", npulse - base, 0);

    // ---- press/release sequence
    key_cycle("star", K_STAR, 4'd10);
    key_cycle("hash", K_HASH, 4'd11);
    key_cycle("kA", K_A, 4'd12);
    key_cycle("kC", K_C, 4'd14);
    key_cycle("kD", K_D, 4'd15);

    // ---- '1' and '4' together: lowest row wins
    base = npulse;
    keys = '0;
    keys[K_1] = 1'b1;
    keys[K_4] = 1'b1;
    ticks(40);
    chk("k14_pulses", npulse - base, 1);
    chk("k14_code", bus.tecla_atual, 4'd1);
    keys = '0;
    ticks(30);

    // ---- '9': brief release, then reset while held
    base = npulse;
    keys[K_9] = 1'b1;
    ticks(40);
    chk("k9_pulses", npulse - base, 1);
    chk("k9_code", bus.tecla_atual, 4'd9);
    keys = '0;
    ticks(2);
    keys[K_9] = 1'b1;
    ticks(30);
    chk("k9_no_repulse", npulse - base, 1);
    rst = 1'b1;
    #1;
    chk("k9_rst_ativo", bus.ativo, 1'b0);
    chk("k9_rst_tecla", bus.tecla_atual, 4'd0);
    chk("k9_rst_colunas", bus.colunas, 4'b1110);
    ticks(2);
    base = npulse;
    rst = 1'b0;
    ticks(40);
    chk("k9_redetect_pulses", npulse - base, 1);
    chk("k9_redetect_code", bus.tecla_atual, 4'd9);
    ticks(30);
    chk("k9_redetect_once", npulse - base, 1);
    keys = '0;
    ticks(30);

    chk("no_back_to_back", dbl, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
